// File: rtl/trivium_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : trivium_arbiter
// Brief    : Two-requester session arbiter sequencing key load, init and
//            byte streaming through a shared Trivium cipher core.
// Revision : 1.0
// ============================================================================
module trivium_arbiter #(
  parameter int INIT_CYCLES = 1152,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [79:0] key0,
  input  logic [79:0] key1,
  input  logic [7:0]  len0,
  input  logic [7:0]  len1,
  input  logic [7:0]  din0,
  input  logic [7:0]  din1,
  input  logic [1:0]  din_vld,
  output logic [1:0]  din_rdy,
  output logic [1:0]  gnt,
  output logic [7:0]  dout,
  output logic        dout_vld,
  output logic        dout_id,
  output logic [1:0]  done,
  output logic [1:0]  err,
  input  logic        out_full,
  output logic        busy,
  output logic        core_key,
  output logic        core_strob_key,
  output logic [7:0]  core_data,
  output logic        core_strob_data,
  output logic [1:0]  core_fifo_cnd,
  input  logic [7:0]  core_stream,
  input  logic        core_wt_sgn
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_GRANT     = 4'd1;
  localparam logic [3:0] S_LOAD_KEY  = 4'd2;
  localparam logic [3:0] S_KEY_END   = 4'd3;
  localparam logic [3:0] S_INIT_WAIT = 4'd4;
  localparam logic [3:0] S_FEED      = 4'd5;
  localparam logic [3:0] S_WAIT_OUT  = 4'd6;
  localparam logic [3:0] S_DONE      = 4'd7;
  localparam logic [3:0] S_ERR       = 4'd8;

  localparam logic [11:0] INIT_LAST = 12'(INIT_CYCLES - 1);
  localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT - 1);

  logic [3:0]  state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic [79:0] key_q, key_d;
  logic [7:0]  len_q, len_d;
  logic [6:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [11:0] init_cnt_q, init_cnt_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic [7:0]  core_data_q, core_data_d;
  logic        core_strob_data_q, core_strob_data_d;
  logic [7:0]  dout_q, dout_d;
  logic        dout_vld_q, dout_vld_d;
  logic        dout_id_q, dout_id_d;

  logic        xfer;
  logic        in_session;
  logic [1:0]  owner_oh;

  assign xfer       = (state_q == S_FEED) && din_vld[owner_q] && !out_full;
  assign in_session = state_q inside {S_GRANT, S_LOAD_KEY, S_KEY_END,
                                      S_INIT_WAIT, S_FEED, S_WAIT_OUT};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= S_IDLE;
      last_q            <= 1'b1;
      owner_q           <= 1'b0;
      key_q             <= '0;
      len_q             <= '0;
      bit_cnt_q         <= '0;
      byte_cnt_q        <= '0;
      init_cnt_q        <= '0;
      to_cnt_q          <= '0;
      core_data_q       <= '0;
      core_strob_data_q <= 1'b0;
      dout_q            <= '0;
      dout_vld_q        <= 1'b0;
      dout_id_q         <= 1'b0;
    end else begin
      state_q           <= state_d;
      last_q            <= last_d;
      owner_q           <= owner_d;
      key_q             <= key_d;
      len_q             <= len_d;
      bit_cnt_q         <= bit_cnt_d;
      byte_cnt_q        <= byte_cnt_d;
      init_cnt_q        <= init_cnt_d;
      to_cnt_q          <= to_cnt_d;
      core_data_q       <= core_data_d;
      core_strob_data_q <= core_strob_data_d;
      dout_q            <= dout_d;
      dout_vld_q        <= dout_vld_d;
      dout_id_q         <= dout_id_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    last_d            = last_q;
    owner_d           = owner_q;
    key_d             = key_q;
    len_d             = len_q;
    bit_cnt_d         = bit_cnt_q;
    byte_cnt_d        = byte_cnt_q;
    init_cnt_d        = init_cnt_q;
    to_cnt_d          = to_cnt_q;
    core_data_d       = core_data_q;
    core_strob_data_d = 1'b0;
    dout_d            = dout_q;
    dout_vld_d        = 1'b0;
    dout_id_d         = dout_id_q;

    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          // Contention alternates: grant whichever index did not win last time.
          owner_d = (req == 2'b11) ? ~last_q : req[1];
          last_d  = owner_d;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        key_d      = owner_q ? key1 : key0;
        len_d      = owner_q ? len1 : len0;
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
        init_cnt_d = '0;
        to_cnt_d   = '0;
        state_d    = S_LOAD_KEY;
      end
      S_LOAD_KEY: begin
        key_d     = {key_q[78:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 7'd1;
        if (bit_cnt_q == 7'd79) state_d = S_KEY_END;
      end
      S_KEY_END: begin
        init_cnt_d = '0;
        state_d    = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (init_cnt_q == INIT_LAST) state_d = S_FEED;
        else                         init_cnt_d = init_cnt_q + 12'd1;
      end
      S_FEED: begin
        if (xfer) begin
          core_data_d       = owner_q ? din1 : din0;
          core_strob_data_d = 1'b1;
          to_cnt_d          = '0;
          state_d           = S_WAIT_OUT;
        end
      end
      S_WAIT_OUT: begin
        // A core response in the expiry cycle takes priority over the timeout.
        if (core_wt_sgn) begin
          dout_d     = core_stream;
          dout_id_d  = owner_q;
          dout_vld_d = 1'b1;
          if (byte_cnt_q == len_q) begin
            state_d = S_DONE;
          end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
            state_d    = S_FEED;
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_ERR;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Owner withdrawing its request aborts the session and drops any in-flight byte.
    if (in_session && !req[owner_q]) begin
      state_d           = S_ERR;
      dout_vld_d        = 1'b0;
      core_strob_data_d = 1'b0;
    end
  end

  always_comb begin
    owner_oh       = owner_q ? 2'b10 : 2'b01;
    busy           = (state_q != S_IDLE);
    gnt            = busy ? owner_oh : 2'b00;
    din_rdy        = 2'b00;
    done           = 2'b00;
    err            = 2'b00;
    core_key       = 1'b0;
    core_strob_key = 1'b0;
    case (state_q)
      S_LOAD_KEY: begin
        core_strob_key = 1'b1;
        core_key       = key_q[79];
      end
      S_FEED:  din_rdy = out_full ? 2'b00 : owner_oh;
      S_DONE:  done    = owner_oh;
      S_ERR:   err     = owner_oh;
      default: ;
    endcase
  end

  assign core_data       = core_data_q;
  assign core_strob_data = core_strob_data_q;
  assign core_fifo_cnd   = {1'b0, out_full};
  assign dout            = dout_q;
  assign dout_vld        = dout_vld_q;
  assign dout_id         = dout_id_q;

endmodule
`default_nettype wire

// File: tb/tb_trivium_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_trivium_arbiter
// Brief    : Directed self-checking bench for trivium_arbiter with a simple
//            echoing core model (stream = data ^ 8'h5A).
// Revision : 1.0
// ============================================================================
module tb_trivium_arbiter;

  localparam int TB_INIT = 16;
  localparam int TB_TO   = 12;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [79:0] key0, key1;
  logic [7:0]  len0, len1, din0, din1;
  logic [1:0]  din_vld, din_rdy, gnt, done, err, core_fifo_cnd;
  logic [7:0]  dout, core_data, core_stream;
  logic        dout_vld, dout_id, out_full, busy;
  logic        core_key, core_strob_key, core_strob_data, core_wt_sgn;

  trivium_arbiter #(.INIT_CYCLES(TB_INIT), .TIMEOUT(TB_TO)) dut (
    .clk(clk), .rst(rst), .req(req), .key0(key0), .key1(key1),
    .len0(len0), .len1(len1), .din0(din0), .din1(din1),
    .din_vld(din_vld), .din_rdy(din_rdy), .gnt(gnt), .dout(dout),
    .dout_vld(dout_vld), .dout_id(dout_id), .done(done), .err(err),
    .out_full(out_full), .busy(busy), .core_key(core_key),
    .core_strob_key(core_strob_key), .core_data(core_data),
    .core_strob_data(core_strob_data), .core_fifo_cnd(core_fifo_cnd),
    .core_stream(core_stream), .core_wt_sgn(core_wt_sgn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: answers echo_dly cycles after each core_strob_data.
  int   cd        = 0;
  int   echo_dly  = 3;
  logic wt_model  = 1'b0;
  logic wt_manual = 1'b0;
  assign core_wt_sgn = wt_model | wt_manual;
  assign core_stream = core_data ^ 8'h5A;

  always @(negedge clk) begin
    wt_model = 1'b0;
    if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) wt_model = 1'b1;
    end
    if (core_strob_data && echo_dly > 0) cd = echo_dly;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [79:0] g_kbits;
  int          g_nkey, g_nvld, g_nstrob, g_strob_cyc, g_end_cyc;
  logic [1:0]  g_first_gnt, g_rdy, g_done, g_err;
  logic [7:0]  g_dout;
  logic        g_id;

  task automatic run_sess(input int budget);
    g_kbits = '0; g_nkey = 0; g_nvld = 0; g_nstrob = 0;
    g_strob_cyc = -1; g_end_cyc = -1;
    g_first_gnt = 2'b00; g_rdy = 2'b00; g_done = 2'b00; g_err = 2'b00;
    g_dout = 8'h00; g_id = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (g_first_gnt == 2'b00) g_first_gnt = gnt;
      if (core_strob_key) begin
        g_kbits = {g_kbits[78:0], core_key};
        g_nkey++;
      end
      if (din_rdy != 2'b00 && g_rdy == 2'b00) g_rdy = din_rdy;
      if (core_strob_data) begin
        g_nstrob++;
        if (g_strob_cyc < 0) g_strob_cyc = c;
      end
      if (dout_vld) begin
        g_nvld++;
        g_dout = dout;
        g_id   = dout_id;
      end
      if ((done | err) != 2'b00) begin
        g_done    = done;
        g_err     = err;
        g_end_cyc = c;
        break;
      end
    end
  endtask

  task automatic wait_key_end(output bit ok);
    bit seen = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (core_strob_key) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct packed {
    logic [1:0] req;
    logic [7:0] len;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] exp_gnt;
    logic [7:0] exp_dout;
    logic       exp_id;
    logic [8:0] exp_nvld;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit found;

    vecs[0] = '{req: 2'b11, len: 8'd0, d0: 8'h3C, d1: 8'hC3, exp_gnt: 2'b01, exp_dout: 8'h66, exp_id: 1'b0, exp_nvld: 9'd1};
    vecs[1] = '{req: 2'b11, len: 8'd0, d0: 8'h3C, d1: 8'hC3, exp_gnt: 2'b10, exp_dout: 8'h99, exp_id: 1'b1, exp_nvld: 9'd1};
    vecs[2] = '{req: 2'b01, len: 8'd1, d0: 8'hA5, d1: 8'h00, exp_gnt: 2'b01, exp_dout: 8'hFF, exp_id: 1'b0, exp_nvld: 9'd2};
    vecs[3] = '{req: 2'b11, len: 8'd0, d0: 8'h00, d1: 8'h12, exp_gnt: 2'b10, exp_dout: 8'h48, exp_id: 1'b1, exp_nvld: 9'd1};
    vecs[4] = '{req: 2'b10, len: 8'd0, d0: 8'hFF, d1: 8'hFF, exp_gnt: 2'b10, exp_dout: 8'hA5, exp_id: 1'b1, exp_nvld: 9'd1};
    vecs[5] = '{req: 2'b11, len: 8'd0, d0: 8'hFF, d1: 8'h00, exp_gnt: 2'b01, exp_dout: 8'hA5, exp_id: 1'b0, exp_nvld: 9'd1};

    rst = 1'b0; req = 2'b00; out_full = 1'b0; din_vld = 2'b11;
    key0 = 80'h8000_0000_0000_0000_0001;
    key1 = 80'h0123_4567_89AB_CDEF_F00D;
    len0 = 8'd0; len1 = 8'd0; din0 = 8'h00; din1 = 8'h00;
    repeat (3) tick();
    chk("rst_gnt", 80'(gnt), 80'h0);
    chk("rst_busy", 80'(busy), 80'h0);
    chk("rst_outs", 80'({dout_vld, done, err, din_rdy, core_strob_key, core_strob_data}), 80'h0);
    chk("rst_data", 80'({dout, core_data}), 80'h0);
    rst = 1'b1;
    tick();

    // Back-to-back sessions, request held between them where the table repeats it.
    for (int i = 0; i < 6; i++) begin
      req = vecs[i].req; len0 = vecs[i].len; len1 = vecs[i].len;
      din0 = vecs[i].d0; din1 = vecs[i].d1;
      run_sess(800);
      chk($sformatf("v%0d_gnt", i), 80'(g_first_gnt), 80'(vecs[i].exp_gnt));
      chk($sformatf("v%0d_rdy", i), 80'(g_rdy), 80'(vecs[i].exp_gnt));
      chk($sformatf("v%0d_nkey", i), 80'(g_nkey), 80'd80);
      chk($sformatf("v%0d_key", i), g_kbits, vecs[i].exp_gnt[1] ? key1 : key0);
      chk($sformatf("v%0d_nvld", i), 80'(g_nvld), 80'(vecs[i].exp_nvld));
      chk($sformatf("v%0d_dout", i), 80'({g_id, g_dout}), 80'({vecs[i].exp_id, vecs[i].exp_dout}));
      chk($sformatf("v%0d_end", i), 80'({g_done, g_err}), 80'({vecs[i].exp_gnt, 2'b00}));
      if (i == 0) chk("v0_strob_cycle", 80'(g_strob_cyc), 80'(83 + TB_INIT));
    end
    req = 2'b00;
    repeat (2) tick();

    // Core never answers: error exactly TB_TO cycles after WAIT_OUT entry.
    echo_dly = 0; req = 2'b01; len0 = 8'd0; din0 = 8'h11;
    run_sess(400);
    chk("to_err", 80'({g_done, g_err}), 80'({2'b00, 2'b01}));
    chk("to_delay", 80'(g_end_cyc - g_strob_cyc), 80'(TB_TO));
    chk("to_nvld", 80'(g_nvld), 80'd0);
    req = 2'b00;
    tick();
    chk("to_gnt_after", 80'(gnt), 80'h0);
    tick();

    // Response arriving in the expiry cycle completes normally.
    req = 2'b01; din0 = 8'h11;
    found = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (core_strob_data) begin
        found = 1'b1;
        break;
      end
    end
    chk("exp_strob_found", 80'(found), 80'd1);
    repeat (TB_TO - 1) tick();
    wt_manual = 1'b1;
    tick();
    wt_manual = 1'b0;
    chk("exp_done", 80'({done, err}), 80'({2'b01, 2'b00}));
    chk("exp_dout", 80'({dout_vld, dout}), 80'({1'b1, 8'h4B}));
    req = 2'b00;
    repeat (2) tick();

    // Owner drops request during INIT_WAIT.
    echo_dly = 3; req = 2'b01;
    wait_key_end(ok);
    chk("drop_keyend", 80'(ok), 80'd1);
    repeat (5) tick();
    req = 2'b00;
    tick();
    chk("drop_err", 80'({done, err, core_strob_data}), 80'({2'b00, 2'b01, 1'b0}));
    tick();
    chk("drop_gnt_after", 80'({gnt, err}), 80'h0);
    tick();

    // Sink full during FEED stalls the transfer; stray core strobe is ignored.
    out_full = 1'b1; req = 2'b01; din0 = 8'h5A;
    wait_key_end(ok);
    repeat (TB_INIT + 3) tick();
    chk("full_rdy", 80'(din_rdy), 80'h0);
    chk("full_fifo_cnd", 80'(core_fifo_cnd), 80'h1);
    chk("full_busy_nostrob", 80'({busy, core_strob_data}), 80'({1'b1, 1'b0}));
    wt_manual = 1'b1;
    tick();
    wt_manual = 1'b0;
    tick();
    chk("stray_wt_no_vld", 80'(dout_vld), 80'h0);
    out_full = 1'b0;
    #1;
    chk("release_rdy", 80'({core_fifo_cnd, din_rdy}), 80'({2'b00, 2'b01}));
    run_sess(100);
    chk("release_done", 80'({g_done, g_err}), 80'({2'b01, 2'b00}));
    chk("release_dout", 80'({g_nvld[3:0], g_dout}), 80'({4'd1, 8'h00}));
    req = 2'b00;
    repeat (2) tick();

    // Asynchronous reset mid-session, then contested grant restarts at index 0.
    req = 2'b10;
    repeat (30) tick();
    rst = 1'b0;
    #1;
    chk("midrst_idle", 80'({busy, gnt, done, err, core_strob_key}), 80'h0);
    repeat (2) tick();
    req = 2'b11; din0 = 8'hC0;
    rst = 1'b1;
    run_sess(800);
    chk("midrst_gnt", 80'(g_first_gnt), 80'h1);
    chk("midrst_done", 80'({g_done, g_err, g_dout}), 80'({2'b01, 2'b00, 8'h9A}));
    req = 2'b00;
    repeat (2) tick();

    // Maximum session length: 256 bytes.
    req = 2'b01; len0 = 8'd255; din0 = 8'h77;
    run_sess(3000);
    chk("long_nvld", 80'(g_nvld), 80'd256);
    chk("long_nstrob", 80'(g_nstrob), 80'd256);
    chk("long_end", 80'({g_done, g_err, g_dout}), 80'({2'b01, 2'b00, 8'h2D}));
    req = 2'b00;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
